// File: rtl/bip_control.sv
// Multi-cycle instruction sequencer for the accumulator processor.
// Fetch/decode/memory-read/execute FSM with Moore-decoded datapath controls and debug counters.
module bip_control #(
    parameter int unsigned OPCODE_W = 5,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                step_mode,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                rd_rom,
    output logic                wr_pc,
    output logic                wr_acc,
    output logic [1:0]          sel_a,
    output logic                sel_b,
    output logic                alu_op,
    output logic                rd_ram,
    output logic                wr_ram,
    output logic                busy,
    output logic                halted,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StMemrd,
        StExec,
        StHalt
    } state_e;

    localparam logic [OPCODE_W-1:0] OpHlt  = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OpSto  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OpLd   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OpLdi  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OpAdd  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OpSub  = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OpSubi = OPCODE_W'(7);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]    instr_count_q, instr_count_d;
    logic                needs_memrd;
    logic                is_busy;

    assign needs_memrd = (opcode == OpLd) || (opcode == OpAdd) || (opcode == OpSub);
    assign is_busy     = (state_q == StFetch) || (state_q == StDecode) ||
                         (state_q == StMemrd) || (state_q == StExec);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            ir_q          <= '0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                ir_d = opcode;
                if (opcode == OpHlt) begin
                    state_d = StHalt;
                end else if (needs_memrd) begin
                    state_d = StMemrd;
                end else begin
                    state_d = StExec;
                end
            end
            StMemrd:  state_d = StExec;
            StExec:   state_d = step_mode ? StIdle : StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // An HLT retires at decode since it never reaches EXEC.
    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (is_busy) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
        if ((state_q == StExec) || ((state_q == StDecode) && (opcode == OpHlt))) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    always_comb begin
        rd_rom = 1'b0;
        wr_pc  = 1'b0;
        wr_acc = 1'b0;
        sel_a  = 2'b00;
        sel_b  = 1'b0;
        alu_op = 1'b0;
        rd_ram = 1'b0;
        wr_ram = 1'b0;
        busy   = is_busy;
        halted = (state_q == StHalt);
        if (state_q == StFetch) begin
            rd_rom = 1'b1;
        end
        if (state_q == StMemrd) begin
            rd_ram = 1'b1;
        end
        if (state_q == StExec) begin
            wr_pc = 1'b1;
            case (ir_q)
                OpSto: wr_ram = 1'b1;
                OpLd: begin
                    wr_acc = 1'b1;
                    rd_ram = 1'b1;
                end
                OpLdi: begin
                    wr_acc = 1'b1;
                    sel_a  = 2'b01;
                end
                OpAdd, OpSub: begin
                    wr_acc = 1'b1;
                    sel_a  = 2'b10;
                    rd_ram = 1'b1;
                    alu_op = (ir_q == OpSub);
                end
                OpAddi, OpSubi: begin
                    wr_acc = 1'b1;
                    sel_a  = 2'b10;
                    sel_b  = 1'b1;
                    alu_op = (ir_q == OpSubi);
                end
                default: ;
            endcase
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: directed scenarios plus random programs
// compared cycle by cycle against an instruction-level reference model.
module tb_bip_control;

    localparam int OW = 5;
    localparam int CW = 32;

    // Expected-output vector bit positions.
    localparam int BRdRom = 10;
    localparam int BWrPc  = 9;
    localparam int BWrAcc = 8;
    localparam int BSelB  = 5;
    localparam int BAlu   = 4;
    localparam int BRdRam = 3;
    localparam int BWrRam = 2;
    localparam int BBusy  = 1;
    localparam int BHalt  = 0;

    typedef enum int {PIdle, PFetch, PDec, PMem, PExec, PHalt} phase_e;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          step_mode = 1'b0;
    logic [OW-1:0] opcode;
    logic          rd_rom, wr_pc, wr_acc, sel_b, alu_op, rd_ram, wr_ram, busy, halted;
    logic [1:0]    sel_a;
    logic [CW-1:0] cycle_count, instr_count;
    logic [10:0]   obs_vec;

    logic [OW-1:0] rom [16];
    logic [3:0]    pc;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [CW-1:0] exp_cyc, exp_ins;

    bip_control #(
        .OPCODE_W(OW),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .step_mode  (step_mode),
        .opcode     (opcode),
        .rd_rom     (rd_rom),
        .wr_pc      (wr_pc),
        .wr_acc     (wr_acc),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .alu_op     (alu_op),
        .rd_ram     (rd_ram),
        .wr_ram     (wr_ram),
        .busy       (busy),
        .halted     (halted),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Program counter stand-in so the ROM follows the PC advance strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else if (wr_pc) pc <= pc + 4'd1;
    end

    assign opcode  = rom[pc];
    assign obs_vec = {rd_rom, wr_pc, wr_acc, sel_a, sel_b, alu_op, rd_ram, wr_ram, busy, halted};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [10:0] exp_out(input phase_e ph, input logic [OW-1:0] op);
        logic [10:0] v;
        v = '0;
        case (ph)
            PFetch: begin v[BRdRom] = 1'b1; v[BBusy] = 1'b1; end
            PDec:   v[BBusy] = 1'b1;
            PMem:   begin v[BRdRam] = 1'b1; v[BBusy] = 1'b1; end
            PHalt:  v[BHalt] = 1'b1;
            PExec: begin
                v[BBusy] = 1'b1;
                v[BWrPc] = 1'b1;
                case (op)
                    5'd1: v[BWrRam] = 1'b1;
                    5'd2: begin v[BWrAcc] = 1'b1; v[BRdRam] = 1'b1; end
                    5'd3: begin v[BWrAcc] = 1'b1; v[7:6] = 2'b01; end
                    5'd4, 5'd6: begin
                        v[BWrAcc] = 1'b1; v[7:6] = 2'b10; v[BRdRam] = 1'b1;
                        v[BAlu] = (op == 5'd6);
                    end
                    5'd5, 5'd7: begin
                        v[BWrAcc] = 1'b1; v[7:6] = 2'b10; v[BSelB] = 1'b1;
                        v[BAlu] = (op == 5'd7);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return v;
    endfunction

    // Compare one observed cycle, then account for it in the counter model.
    task automatic observe(input string tag, input phase_e ph, input logic [OW-1:0] op);
        check({tag, "/outs"}, 64'(obs_vec), 64'(exp_out(ph, op)));
        check({tag, "/cyc"}, 64'(cycle_count), 64'(exp_cyc));
        check({tag, "/ins"}, 64'(instr_count), 64'(exp_ins));
        if (ph inside {PFetch, PDec, PMem, PExec}) exp_cyc++;
        if (ph == PExec || (ph == PDec && op == 5'd0)) exp_ins++;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        start   = 1'b0;
        exp_cyc = '0;
        exp_ins = '0;
        #1;
        observe("reset_async", PIdle, 5'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        observe("post_reset", PIdle, 5'd0);
    endtask

    task automatic halt_check();
        @(negedge clk);
        observe("halt", PHalt, 5'd0);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            observe("halt_start", PHalt, 5'd0);
            @(negedge clk);
            observe("halt_after", PHalt, 5'd0);
        end
    endtask

    // Runs rom[0..n-1]; called at a negedge with the DUT in IDLE.
    task automatic run_prog(input int n, input bit step);
        logic [OW-1:0] op;
        step_mode = step;
        for (int i = 0; i < n; i++) begin
            op = rom[i];
            if (i == 0 || step) start = 1'b1;
            @(negedge clk);
            observe("fetch", PFetch, op);
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            observe("decode", PDec, op);
            start = 1'($urandom_range(0, 1));
            if (op == 5'd0) begin
                halt_check();
                return;
            end
            if (op == 5'd2 || op == 5'd4 || op == 5'd6) begin
                @(negedge clk);
                observe("memrd", PMem, op);
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            observe("exec", PExec, op);
            start = 1'b0;
            if (step) begin
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    observe("step_idle", PIdle, op);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 5'd31;
        #1;
        do_reset();

        // LDI then HLT, free-running.
        rom[0] = 5'd3; rom[1] = 5'd0;
        run_prog(2, 1'b0);
        check("t1_cycle_count", 64'(cycle_count), 64'd5);
        check("t1_instr_count", 64'(instr_count), 64'd2);

        // ADD then HLT.
        do_reset();
        rom[0] = 5'd4; rom[1] = 5'd0;
        run_prog(2, 1'b0);

        // Step mode: SUBI, undefined opcode, then HLT.
        do_reset();
        rom[0] = 5'd7; rom[1] = 5'd31; rom[2] = 5'd0;
        run_prog(3, 1'b1);
        check("t3_instr_count", 64'(instr_count), 64'd3);

        // Reset asserted during EXEC of STO.
        do_reset();
        rom[0] = 5'd1; rom[1] = 5'd0;
        step_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        observe("sto_fetch", PFetch, 5'd1);
        @(negedge clk);
        observe("sto_decode", PDec, 5'd1);
        @(negedge clk);
        observe("sto_exec", PExec, 5'd1);
        #2;
        do_reset();

        // Random programs, each terminated by HLT.
        for (int t = 0; t < 20; t++) begin
            int n;
            do_reset();
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n - 1; i++) rom[i] = 5'($urandom_range(1, 31));
            rom[n - 1] = 5'd0;
            run_prog(n, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
